// File: rtl/program_loader.sv
// program_loader: packs a UART byte stream (first byte most significant) into
// 32-bit words and writes them to instruction memory at consecutive word
// addresses from 0, stopping on HALT_WORD or when memory is full.
module program_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_program_memory_write,
  output logic [31:0]       o_instruction_write,
  output logic [ADDR_W-1:0] o_address_write,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t            state;
  logic [31:0]       word;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        byte_cnt;
  logic              overflow;

  // Loader state machine: byte packing, word address and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word     <= '0;
      addr     <= '0;
      byte_cnt <= 2'd0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state    <= RECV;
            addr     <= '0;
            byte_cnt <= 2'd0;
            overflow <= 1'b0;
          end
        end
        RECV: begin
          if (i_rx_valid) begin
            word     <= {word[23:0], i_rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          // Halt takes priority; the full check uses addr before any increment.
          if (word == HALT_WORD) begin
            state    <= DONE;
            overflow <= 1'b0;
          end else if (addr == ADDR_LAST) begin
            state    <= DONE;
            overflow <= 1'b1;
          end else begin
            state <= RECV;
            addr  <= addr + ADDR_W'(1);
            // A byte landing in the strobe cycle starts the next word.
            if (i_rx_valid) begin
              word     <= {word[23:0], i_rx_data};
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs come straight from state-machine registers only.
  assign o_program_memory_write = (state == WRITE);
  assign o_instruction_write    = word;
  assign o_address_write        = addr;
  assign o_busy                 = (state == RECV) || (state == WRITE);
  assign o_done                 = (state == DONE);
  assign o_overflow             = overflow;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a per-cycle vector table on an 8-bit
// address instance, plus a hand-written overflow sequence on a 2-bit one.
module tb_program_loader;

  logic        clk;
  logic        rst, start, valid;
  logic [7:0]  data;
  logic        wr, busy, done, ovf;
  logic [31:0] word;
  logic [7:0]  addr;

  logic        rst_b, start_b, valid_b;
  logic [7:0]  data_b;
  logic        wr_b, busy_b, done_b, ovf_b;
  logic [31:0] word_b;
  logic [1:0]  addr_b;

  int errors = 0;
  int checks = 0;
  int strobes_a = 0;
  logic [31:0] addr_q_b[$];
  logic [31:0] data_q_b[$];

  typedef struct {
    logic        rst, start, valid;
    logic [7:0]  data;
    logic        chk_ad;
    logic        wr;
    logic [31:0] word;
    logic [7:0]  addr;
    logic        busy, done, ovf;
  } vec_t;

  vec_t vecs[$];

  program_loader #(.ADDR_W(8)) dut_a (
    .clk(clk), .rst(rst), .i_start(start), .i_rx_data(data), .i_rx_valid(valid),
    .o_program_memory_write(wr), .o_instruction_write(word), .o_address_write(addr),
    .o_busy(busy), .o_done(done), .o_overflow(ovf)
  );

  program_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst_b), .i_start(start_b), .i_rx_data(data_b), .i_rx_valid(valid_b),
    .o_program_memory_write(wr_b), .o_instruction_write(word_b), .o_address_write(addr_b),
    .o_busy(busy_b), .o_done(done_b), .o_overflow(ovf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count strobes on instance a; log every write on instance b.
  always @(negedge clk) begin
    if (wr === 1'b1) strobes_a++;
    if (wr_b === 1'b1) begin
      addr_q_b.push_back(32'(addr_b));
      data_q_b.push_back(word_b);
    end
  end

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, row, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic v, input logic [7:0] d,
                     input logic ca, input logic w, input logic [31:0] wd,
                     input logic [7:0] a, input logic b, input logic dn, input logic o);
    vec_t t;
    t.rst = r; t.start = s; t.valid = v; t.data = d;
    t.chk_ad = ca; t.wr = w; t.word = wd; t.addr = a;
    t.busy = b; t.done = dn; t.ovf = o;
    vecs.push_back(t);
  endtask

  // Byte in RECV, no write expected.
  task automatic byte_busy(input logic [7:0] d);
    add(0, 0, 1, d, 0, 0, 32'h0, 8'h0, 1, 0, 0);
  endtask

  // Byte completing a word: write expected next cycle.
  task automatic byte_write(input logic [7:0] d, input logic [31:0] wd, input logic [7:0] a);
    add(0, 0, 1, d, 1, 1, wd, a, 1, 0, 0);
  endtask

  // Outputs fully quiet (reset / idle), address and data at zero.
  task automatic quiet(input logic r, input logic v, input logic [7:0] d);
    add(r, 0, v, d, 1, 0, 32'h0, 8'h0, 0, 0, 0);
  endtask

  task automatic build_table();
    quiet(1, 0, 8'h00);                               // reset state
    quiet(0, 1, 8'hAA);                               // byte ignored in IDLE
    add(0, 1, 0, 8'h00, 0, 0, 32'h0, 8'h0, 1, 0, 0);  // start -> busy
    byte_busy(8'h20); byte_busy(8'h08); byte_busy(8'h00);
    byte_write(8'h05, 32'h2008_0005, 8'd0);
    add(0, 0, 0, 8'h00, 0, 0, 32'h0, 8'h0, 1, 0, 0);  // back in RECV
    byte_busy(8'hFF); byte_busy(8'hFF); byte_busy(8'hFF);
    byte_write(8'hFF, 32'hFFFF_FFFF, 8'd1);
    add(0, 0, 0, 8'h00, 0, 0, 32'h0, 8'h0, 0, 1, 0);  // halt -> done
    add(0, 0, 1, 8'h11, 0, 0, 32'h0, 8'h0, 0, 1, 0);  // byte dropped in DONE
    add(0, 1, 0, 8'h00, 0, 0, 32'h0, 8'h0, 1, 0, 0);  // restart clears done
    byte_busy(8'h00); byte_busy(8'h00); byte_busy(8'h00);
    byte_write(8'h01, 32'h0000_0001, 8'd0);
    byte_busy(8'h12);                                 // arrives in WRITE cycle
    byte_busy(8'h34); byte_busy(8'h56);
    byte_write(8'h78, 32'h1234_5678, 8'd1);
    byte_busy(8'hFF);                                 // arrives in WRITE cycle
    byte_busy(8'hFF); byte_busy(8'hFF);
    byte_write(8'hFF, 32'hFFFF_FFFF, 8'd2);
    add(0, 0, 1, 8'h99, 0, 0, 32'h0, 8'h0, 0, 1, 0);  // byte during final WRITE dropped
    add(0, 1, 0, 8'h00, 0, 0, 32'h0, 8'h0, 1, 0, 0);  // restart
    byte_busy(8'hAB); byte_busy(8'hCD);
    add(0, 1, 0, 8'h00, 0, 0, 32'h0, 8'h0, 1, 0, 0);  // start ignored in RECV
    byte_busy(8'hEF);
    byte_write(8'h01, 32'hABCD_EF01, 8'd0);
    add(0, 0, 0, 8'h00, 0, 0, 32'h0, 8'h0, 1, 0, 0);
    byte_busy(8'h11); byte_busy(8'h22);               // partial word pending
    quiet(1, 0, 8'h00);                               // reset mid-word
    quiet(0, 1, 8'h01); quiet(0, 1, 8'h02);
    quiet(0, 1, 8'h03); quiet(0, 1, 8'h04);           // no start: never written
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; valid = 1'b0; data = 8'h00;
    rst_b = 1'b0; start_b = 1'b0; valid_b = 1'b0; data_b = 8'h00;
    build_table();

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; start = vecs[i].start;
      valid = vecs[i].valid; data = vecs[i].data;
      @(posedge clk); #1;
      chk("write_strobe", i, 32'(wr), 32'(vecs[i].wr));
      chk("busy", i, 32'(busy), 32'(vecs[i].busy));
      chk("done", i, 32'(done), 32'(vecs[i].done));
      chk("overflow", i, 32'(ovf), 32'(vecs[i].ovf));
      if (vecs[i].chk_ad) begin
        chk("write_data", i, word, vecs[i].word);
        chk("write_addr", i, 32'(addr), 32'(vecs[i].addr));
      end
    end
    rst = 1'b0; start = 1'b0; valid = 1'b0;
    @(negedge clk); #1;
    chk("strobe_count_a", -1, 32'(strobes_a), 32'd6);

    // Overflow on a 4-word memory: 20 back-to-back bytes, 5th word dropped.
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      valid_b = 1'b1;
      data_b  = 8'(i + 1);
      @(posedge clk); #1;
    end
    valid_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_strobe_count", -1, 32'(addr_q_b.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < addr_q_b.size()) begin
        chk("ovf_addr", k, addr_q_b[k], 32'(k));
        chk("ovf_data", k, data_q_b[k],
            {8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)});
      end
    end
    chk("ovf_done", -1, 32'(done_b), 32'd1);
    chk("ovf_flag", -1, 32'(ovf_b), 32'd1);
    chk("ovf_busy", -1, 32'(busy_b), 32'd0);

    // Restart after overflow clears the flag.
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    chk("restart_ovf", -1, 32'(ovf_b), 32'd0);
    chk("restart_done", -1, 32'(done_b), 32'd0);
    chk("restart_busy", -1, 32'(busy_b), 32'd1);
    chk("restart_addr", -1, 32'(addr_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Writer side of the instruction-memory programming port used by the fetch stage. It takes a byte stream from the debug UART receiver and packs every four bytes into one 32-bit instruction word, first byte most significant. Each word is written to instruction memory with a single-cycle write strobe at consecutive word addresses starting from 0. Loading stops on a halt word or when memory is full, and the block then reports done.

## Interface
- ADDR_W, 8, width of the instruction-memory word address; capacity is 2^ADDR_W words
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker; it is written to memory, then loading stops
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- i_start  in  1  arm loader; sampled only in IDLE and DONE
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe; i_rx_data valid this cycle
- o_program_memory_write  out  1  instruction-memory write enable, one-cycle pulse per word
- o_instruction_write  out  32  word to write
- o_address_write  out  ADDR_W  word address to write
- o_busy  out  1  high in RECV and WRITE
- o_done  out  1  load finished; held until restart or reset
- o_overflow  out  1  memory filled before HALT_WORD arrived; valid while o_done=1

## Operation
- States: IDLE, RECV, WRITE, DONE. All outputs are registered or decoded from the state register only. No output is combinational from inputs.
- Reset: state=IDLE. word, addr and byte_cnt are cleared to 0. All outputs are 0.
- IDLE:
  - i_rx_valid is ignored.
  - i_start=1 moves to RECV with addr=0, byte_cnt=0 and o_overflow cleared.
- RECV:
  - On i_rx_valid: word <= {word[23:0], i_rx_data} and byte_cnt increments (2-bit counter).
  - When the accepted byte is the 4th (byte_cnt==3), the next state is WRITE and byte_cnt wraps to 0.
  - i_start is ignored.
- WRITE (exactly one cycle):
  - o_program_memory_write=1, o_instruction_write=word, o_address_write=addr.
  - If word==HALT_WORD, go to DONE with o_overflow=0.
  - Else if addr==2^ADDR_W-1, go to DONE with o_overflow=1 (the last slot is still written).
  - Else addr increments and the state returns to RECV.
- Byte arriving during WRITE:
  - If returning to RECV, it is accepted as byte 0 of the next word.
  - If going to DONE, it is dropped.
- DONE:
  - o_done=1; o_overflow holds its value.
  - Further bytes are dropped.
  - i_start=1 restarts exactly as from IDLE: clears o_done and o_overflow, addr=0, byte_cnt=0, state RECV.
- Partial word: bytes held in RECV with byte_cnt≠0 stay pending indefinitely. There is no timeout.
- Reset mid-operation: takes effect at the next edge, overriding all other conditions. A write pulse pending in WRITE is suppressed and no partial word is ever written.
- Address arithmetic: unsigned, ADDR_W bits, no wrap. The overflow check happens before any increment.

## Timing
- 4th byte sampled at edge k: o_program_memory_write=1 during cycle k→k+1. Address and data are stable for that whole cycle and change only after the strobe drops.
- Minimum byte spacing is 1 cycle (back-to-back strobes are legal), which gives one write per 4 bytes with no dropped bytes.
- o_done rises at the edge ending the final WRITE cycle (1 cycle after the strobe was sampled high).
- i_start in IDLE/DONE at edge j: o_busy=1 from edge j. The first byte is accepted from cycle j+1 onward.
- o_busy falls at the same edge that o_done rises.
- Write-port contract: the memory latches data on the rising edge that ends the strobe cycle.

## Test plan
- Basic load:
  - Stimulus: reset, i_start, then bytes 20 08 00 05 and FF FF FF FF.
  - Response: writes of 0x20080005 at address 0 and 0xFFFFFFFF at address 1, exactly two strobes, then o_done=1 and o_overflow=0.
- Back-to-back bytes:
  - Stimulus: 12 bytes with i_rx_valid high every cycle, the last word being HALT_WORD.
  - Response: 3 strobes at addresses 0, 1, 2 spaced 4 cycles apart, no byte lost. This includes a byte arriving in a WRITE cycle.
- Overflow, ADDR_W=2:
  - Stimulus: 5 non-halt words.
  - Response: writes at addresses 0–3, then DONE with o_overflow=1. The 5th word's bytes are dropped and produce no strobe.
- Reset mid-word:
  - Stimulus: 2 bytes, then rst for 1 cycle, then 4 bytes (no i_start).
  - Response: no strobe ever, state IDLE, all outputs 0.
- Restart from DONE:
  - Stimulus: after a completed load, i_start, then bytes 00 00 00 01 and FF FF FF FF.
  - Response: o_done=0 from the edge after i_start, writes at address 0 (0x00000001) and address 1, then o_done=1.
- Ignored controls:
  - Stimulus: i_start pulsed while in RECV with byte_cnt=2, and bytes sent while in IDLE.
  - Response: addr and byte_cnt unchanged, no strobe.
